// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel window sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package sobel_pkg;

  localparam int DEF_IMG_W = 1280;
  localparam int DEF_IMG_H = 720;
  localparam int DEF_PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Flat slot of window element (row i, col j); row 0 is the oldest line.
  function automatic int win_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line pixel store ({old row, mid row} per column), one shared address.
// Latency: asynchronous read, write lands on the rising edge.
// Backpressure: none; the caller only asserts we on an accepted pixel.
// Ports: clk; we write strobe; addr column; wdata/rdata {old,mid} pair.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = 2 * DEF_PIX_W,
  parameter int AW    = $clog2(DEF_IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read is combinational, so the value seen in the write cycle is the
  // pre-write contents (read-before-write at the same address).
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_sequencer.sv
// Raster pixel stream in, tagged 3x3 windows out (one per interior pixel).
// Latency: 1 cycle from accepting the window's bottom-right pixel to m_valid.
// Backpressure: single output register, no skid; s_ready drops while a
//   window is stalled and for the whole end-of-frame drain.
// Ports: clk/rst (async, active-high); s_valid/s_ready/s_data/s_sof pixel
//   input; m_valid/m_ready/m_win/m_sof/m_eol/m_eof window output;
//   busy (not idle); frame_err (one-cycle pulse on mid-frame s_sof).
module sobel_window_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [9*PIX_W-1:0] m_win,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t        state, state_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [CW-1:0] col, col_nxt;
  logic          accept;
  logic          store;     // pixel goes into line buffers and window
  logic          restart;   // s_sof pixel becomes the new (0,0)
  logic          emit;      // this pixel completes an output window

  logic [CW-1:0]        lb_addr;
  logic [2*PIX_W-1:0]   lb_rdata;
  logic [2*PIX_W-1:0]   lb_wdata;
  logic [PIX_W-1:0]     lb_old, lb_mid;

  logic [2:0][2:0][PIX_W-1:0] win, win_nxt;   // [row][col]
  logic [9*PIX_W-1:0]         win_flat;

  assign s_ready = !rst && (state != DRAIN) && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != IDLE);

  // ---------------- FSM and position counters ----------------
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    store     = 1'b0;
    restart   = 1'b0;
    emit      = 1'b0;
    case (state)
      IDLE: begin
        if (accept && s_sof) begin
          store   = 1'b1;
          restart = 1'b1;
        end
      end
      FILL, RUN: begin
        if (accept) begin
          store = 1'b1;
          if (s_sof) begin
            restart = 1'b1;
          end else begin
            emit = (state == RUN) && (col >= CW'(2));
            if (col == COL_LAST) begin
              col_nxt = '0;
              row_nxt = row + RW'(1);
              if (state == FILL && row == RW'(1)) state_nxt = RUN;
            end else begin
              col_nxt = col + CW'(1);
            end
            if (emit && row == ROW_LAST && col == COL_LAST) begin
              state_nxt = DRAIN;
              row_nxt   = '0;
              col_nxt   = '0;
            end
          end
        end
      end
      DRAIN: begin
        if (m_valid && m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The s_sof pixel is stored at column 0, so the next one is column 1.
    if (restart) begin
      state_nxt = FILL;
      row_nxt   = '0;
      col_nxt   = CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  // ---------------- Line buffers ----------------
  assign lb_addr          = restart ? '0 : col;
  assign {lb_old, lb_mid} = lb_rdata;
  assign lb_wdata         = {lb_mid, s_data};

  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (2 * PIX_W),
    .AW    (CW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (store),
    .addr  (lb_addr),
    .wdata (lb_wdata),
    .rdata (lb_rdata)
  );

  // ---------------- Window shift and output register ----------------
  // Columns move left; the new column is {old row, mid row, incoming pixel}.
  always_comb begin
    win_nxt = win;
    for (int i = 0; i < 3; i++) begin
      win_nxt[i][0] = win[i][1];
      win_nxt[i][1] = win[i][2];
    end
    win_nxt[0][2] = lb_old;
    win_nxt[1][2] = lb_mid;
    win_nxt[2][2] = s_data;
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_flat[PIX_W*win_idx(i, j) +: PIX_W] = win_nxt[i][j];
      end
    end
  end

  // emit implies s_ready, so a stalled window is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win       <= '0;
      m_valid   <= 1'b0;
      m_win     <= '0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
      m_eof     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= restart && (state != IDLE);
      if (store) win <= win_nxt;
      if (emit) begin
        m_valid <= 1'b1;
        m_win   <= win_flat;
        m_sof   <= (row == RW'(2)) && (col == CW'(2));
        m_eol   <= (col == COL_LAST);
        m_eof   <= (row == ROW_LAST) && (col == COL_LAST);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Randomized bench: image-array reference model vs two DUT configurations.
// Latency: n/a.
// Backpressure: m_ready driven randomly or held low in directed stalls.
module tb_sobel_window_sequencer;

  typedef struct {
    logic [71:0] win;
    logic        sof;
    logic        eol;
    logic        eof;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_sof = 1'b0;
  logic        m_ready = 1'b0;
  bit          sel = 1'b0;

  logic        a_s_ready, a_m_valid, a_m_sof, a_m_eol, a_m_eof, a_busy, a_frame_err;
  logic        b_s_ready, b_m_valid, b_m_sof, b_m_eol, b_m_eof, b_busy, b_frame_err;
  logic [71:0] a_m_win, b_m_win;

  logic        s_ready, m_valid, m_sof, m_eol, m_eof, busy, frame_err;
  logic [71:0] m_win;

  assign s_ready   = sel ? b_s_ready   : a_s_ready;
  assign m_valid   = sel ? b_m_valid   : a_m_valid;
  assign m_sof     = sel ? b_m_sof     : a_m_sof;
  assign m_eol     = sel ? b_m_eol     : a_m_eol;
  assign m_eof     = sel ? b_m_eof     : a_m_eof;
  assign busy      = sel ? b_busy      : a_busy;
  assign frame_err = sel ? b_frame_err : a_frame_err;
  assign m_win     = sel ? b_m_win     : a_m_win;

  sobel_window_sequencer #(.IMG_W(4), .IMG_H(3), .PIX_W(8)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_s_ready),
    .s_data(s_data), .s_sof(s_sof), .m_valid(a_m_valid), .m_ready(m_ready),
    .m_win(a_m_win), .m_sof(a_m_sof), .m_eol(a_m_eol), .m_eof(a_m_eof),
    .busy(a_busy), .frame_err(a_frame_err)
  );

  sobel_window_sequencer #(.IMG_W(5), .IMG_H(4), .PIX_W(8)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_s_ready),
    .s_data(s_data), .s_sof(s_sof), .m_valid(b_m_valid), .m_ready(m_ready),
    .m_win(b_m_win), .m_sof(b_m_sof), .m_eol(b_m_eol), .m_eof(b_m_eof),
    .busy(b_busy), .frame_err(b_frame_err)
  );

  always #5 clk = ~clk;

  // Reference model state: the frame as a 2-D image plus expected windows.
  exp_t        q[$];
  int          W = 4, H = 3;
  logic [7:0]  img [8][8];
  int          pos = 0;
  bit          in_frame = 0, ferr_exp = 0;
  int          cyc = 0, n_vec = 0, n_err = 0, n_win = 0, n_ferr = 0;
  bit          prev_valid = 0, prev_hs = 0;
  logic [74:0] prev_out = '0;
  int          rdy_prob = 100, bub_prob = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit rnd_rdy();
    return $urandom_range(99) < rdy_prob;
  endfunction

  task automatic model_accept(input logic [7:0] d, input bit f);
    int r, c;
    exp_t e;
    if (f) begin
      ferr_exp = in_frame;
      in_frame = 1;
      pos = 0;
    end else if (!in_frame) begin
      return;
    end
    r = pos / W;
    c = pos % W;
    img[r][c] = d;
    if (r >= 2 && c >= 2) begin
      e.win = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
      e.sof = (r == 2 && c == 2);
      e.eol = (c == W - 1);
      e.eof = (r == H - 1 && c == W - 1);
      e.acc = cyc;
      q.push_back(e);
    end
    pos++;
    if (pos == W * H) in_frame = 0;
  endtask

  // One clock: drive, check outputs against the model, then update the model.
  task automatic step(input bit v, input logic [7:0] d, input bit f, input bit rdy, output bit acc);
    bit exp_rdy, exp_busy, hs;
    logic [74:0] cur;
    exp_t e;
    @(negedge clk);
    s_valid = v; s_data = d; s_sof = f; m_ready = rdy;
    #1;
    cyc++;
    exp_rdy  = !(q.size() > 0 && q[0].eof) && (q.size() == 0 || rdy);
    exp_busy = in_frame || (q.size() > 0 && q[0].eof);
    check("s_ready", 80'(s_ready), 80'(exp_rdy));
    check("m_valid", 80'(m_valid), 80'(q.size() > 0));
    check("busy", 80'(busy), 80'(exp_busy));
    check("frame_err", 80'(frame_err), 80'(ferr_exp));
    if (frame_err) n_ferr++;
    cur = {m_win, m_sof, m_eol, m_eof};
    if (prev_valid && !prev_hs) check("hold", 80'(cur), 80'(prev_out));
    hs = m_valid && rdy;
    if (m_valid && q.size() > 0) begin
      if (!prev_valid || prev_hs) check("latency", 80'(cyc), 80'(q[0].acc + 1));
      if (hs) begin
        e = q.pop_front();
        check("m_win", 80'(m_win), 80'(e.win));
        check("flags", 80'({m_sof, m_eol, m_eof}), 80'({e.sof, e.eol, e.eof}));
        n_win++;
      end
    end
    prev_valid = m_valid;
    prev_hs    = hs;
    prev_out   = cur;
    ferr_exp   = 0;
    acc = v && s_ready;
    if (acc) model_accept(d, f);
  endtask

  task automatic push_pix(input logic [7:0] d, input bit f);
    bit acc;
    int n;
    n = 0;
    if ($urandom_range(99) < bub_prob) step(1'b0, 8'($urandom), 1'b0, rnd_rdy(), acc);
    do begin
      step(1'b1, d, f, rnd_rdy(), acc);
      n++;
    end while (!acc && n < 300);
    if (!acc) check("accept_timeout", 80'(0), 80'(1));
  endtask

  task automatic send_frame(input bit rnd);
    for (int p = 0; p < W * H; p++)
      push_pix(rnd ? 8'($urandom) : 8'(p), p == 0);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((busy || m_valid) && n < 200) begin
      step(1'b0, 8'd0, 1'b0, rnd_rdy(), acc);
      n++;
    end
    if (n >= 200) check("drain_timeout", 80'(0), 80'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 0; s_sof = 0;
    #2;
    rst = 1;
    #1;
    check("rst_m_valid", 80'(m_valid), 80'(0));
    check("rst_s_ready", 80'(s_ready), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_frame_err", 80'(frame_err), 80'(0));
    check("rst_m_win", 80'(m_win), 80'(0));
    check("rst_flags", 80'({m_sof, m_eol, m_eof}), 80'(0));
    q.delete();
    in_frame = 0; ferr_exp = 0; prev_valid = 0; prev_hs = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bit acc;
    int n;

    // 1: clean frame
    do_reset();
    n_win = 0;
    send_frame(0);
    drain();
    check("t1_windows", 80'(n_win), 80'(2));

    // 2: stall after window 1; pixel 11 must wait
    n_win = 0;
    for (int p = 0; p <= 10; p++) push_pix(8'(p), p == 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'd11, 1'b0, 1'b0, acc);
      check("t2_stalled", 80'(acc), 80'(0));
    end
    push_pix(8'd11, 1'b0);
    drain();
    check("t2_windows", 80'(n_win), 80'(2));

    // 3: stray pixels before s_sof are dropped
    n_win = 0;
    push_pix(8'd5, 1'b0);
    push_pix(8'd6, 1'b0);
    send_frame(0);
    drain();
    check("t3_windows", 80'(n_win), 80'(2));

    // 4: aborted frame, then a full one
    n_win = 0; n_ferr = 0;
    for (int p = 0; p <= 6; p++) push_pix(8'(p), p == 0);
    send_frame(0);
    drain();
    check("t4_frame_err_pulses", 80'(n_ferr), 80'(1));
    check("t4_windows", 80'(n_win), 80'(2));

    // 5: reset while window 1 is stalled
    for (int p = 0; p <= 10; p++) push_pix(8'(p), p == 0);
    step(1'b0, 8'd0, 1'b0, 1'b0, acc);
    do_reset();
    n_win = 0;
    send_frame(0);
    drain();
    check("t5_windows", 80'(n_win), 80'(2));

    // 6: 5x4 image, two back-to-back frames
    sel = 1; W = 5; H = 4;
    do_reset();
    n_win = 0;
    send_frame(0);
    send_frame(0);
    drain();
    check("t6_windows", 80'(n_win), 80'(12));

    // 7: random data, bubbles, backpressure, aborted frames, both sizes
    rdy_prob = 60; bub_prob = 30;
    for (int cfg = 0; cfg < 2; cfg++) begin
      sel = (cfg == 1);
      W = (cfg == 1) ? 5 : 4;
      H = (cfg == 1) ? 4 : 3;
      do_reset();
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(2) == 0) push_pix(8'($urandom), 1'b0);
        if ($urandom_range(2) == 0) begin
          n = $urandom_range(W * H - 1, 1);
          for (int p = 0; p < n; p++) push_pix(8'($urandom), p == 0);
        end
        send_frame(1);
      end
      drain();
      check("t7_queue_empty", 80'(q.size()), 80'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
